// File: rtl/glb_tile_evt_pipe_pkg.sv
// Shared defaults and types for the GLB tile event/packet staging block.
// Latency: n/a (declarations only).
// Backpressure: n/a (pure pulse/pipe logic, no ready signals).
package glb_tile_evt_pipe_pkg;

  localparam int NUM_CH_DEF    = 3;
  localparam int START_LAT_DEF = 1;
  localparam int IRQ_LAT_DEF   = 1;
  localparam int PKT_WIDTH_DEF = 64;
  localparam int PKT_LAT_DEF   = 1;
  localparam int CNT_WIDTH_DEF = 4;

  // Per-channel activity: BUSY from an accepted start until its done pulse.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } evt_state_e;

endpackage

// File: rtl/glb_tile_evt_pipe_if.sv
// Event and packet bundle between the tile boundary/core and the staging block.
// Latency: n/a (wires only).
// Backpressure: none; pulses and packets are fire-and-forget.
interface glb_tile_evt_pipe_if
  import glb_tile_evt_pipe_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int PKT_WIDTH = PKT_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
  logic [NUM_CH-1:0]           start_pulse;
  logic [NUM_CH-1:0]           start_pulse_int;
  logic [NUM_CH-1:0]           done_pulse_int;
  logic [NUM_CH-1:0]           irq_pulse;
  logic [NUM_CH-1:0]           irq_pending;
  logic [NUM_CH*CNT_WIDTH-1:0] irq_count;
  logic [NUM_CH-1:0]           irq_clr;
  logic [NUM_CH-1:0]           busy;
  logic [NUM_CH-1:0]           start_overrun;
  logic [PKT_WIDTH-1:0]        pkt_w2e_in;
  logic [PKT_WIDTH-1:0]        pkt_w2e_out;
  logic [PKT_WIDTH-1:0]        pkt_e2w_in;
  logic [PKT_WIDTH-1:0]        pkt_e2w_out;

  // Driver side: tile boundary plus core completion pulses.
  modport master (
    output start_pulse, done_pulse_int, irq_clr, pkt_w2e_in, pkt_e2w_in,
    input  start_pulse_int, irq_pulse, irq_pending, irq_count, busy,
           start_overrun, pkt_w2e_out, pkt_e2w_out
  );

  // Staging block side.
  modport slave (
    input  start_pulse, done_pulse_int, irq_clr, pkt_w2e_in, pkt_e2w_in,
    output start_pulse_int, irq_pulse, irq_pending, irq_count, busy,
           start_overrun, pkt_w2e_out, pkt_e2w_out
  );
endinterface

// File: rtl/glb_evt_chan.sv
// One event channel: start delay + IDLE/BUSY gate, done-to-irq delay, sticky pending/count/overrun.
// Latency: START_LAT cycles start->start_pulse_int, IRQ_LAT cycles done->irq_pulse, +1 to pending/count.
// Backpressure: none; a start arriving while BUSY is dropped and flagged as overrun.
module glb_evt_chan
  import glb_tile_evt_pipe_pkg::*;
#(
  parameter int START_LAT = START_LAT_DEF,
  parameter int IRQ_LAT   = IRQ_LAT_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_pulse,
  input  logic                 done_pulse,
  input  logic                 irq_clr,
  output logic                 start_pulse_int,
  output logic                 irq_pulse,
  output logic                 irq_pending,
  output logic [CNT_WIDTH-1:0] irq_count,
  output logic                 busy,
  output logic                 start_overrun
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic       st_tap;
  logic       irq_tap;
  logic       start_acc;
  logic       ovr_set;
  evt_state_e state_q;
  evt_state_e state_d;

  // Passthrough taps are gated so outputs stay low while reset is held.
  if (START_LAT == 0) begin : g_st_pass
    assign st_tap = start_pulse & reset;
  end else begin : g_st_dly
    logic [START_LAT-1:0] st_sr;
    // start delay line, shifts every cycle regardless of clk_en
    always_ff @(posedge clk or negedge reset)
      if (!reset) st_sr <= '0;
      else        st_sr <= (st_sr << 1) | START_LAT'(start_pulse);
    assign st_tap = st_sr[START_LAT-1];
  end

  if (IRQ_LAT == 0) begin : g_irq_pass
    assign irq_tap = done_pulse & reset;
  end else begin : g_irq_dly
    logic [IRQ_LAT-1:0] irq_sr;
    // done-to-interrupt delay line; every done is forwarded, never merged
    always_ff @(posedge clk or negedge reset)
      if (!reset) irq_sr <= '0;
      else        irq_sr <= (irq_sr << 1) | IRQ_LAT'(done_pulse);
    assign irq_tap = irq_sr[IRQ_LAT-1];
  end

  // channel state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;

  // start acceptance: a done in the same cycle frees the slot for a new start
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    ovr_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_tap) begin
          start_acc = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (st_tap) begin
          if (done_pulse) start_acc = 1'b1;
          else            ovr_set   = 1'b1;
        end else if (done_pulse) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sticky pending/count/overrun; a new event beats a coincident clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending   <= 1'b0;
      irq_count     <= '0;
      start_overrun <= 1'b0;
    end else begin
      if (irq_tap) begin
        irq_pending <= 1'b1;
        if (irq_clr)                   irq_count <= CNT_ONE;
        else if (irq_count != CNT_MAX) irq_count <= irq_count + 1'b1;
      end else if (irq_clr) begin
        irq_pending <= 1'b0;
        irq_count   <= '0;
      end
      if (ovr_set)      start_overrun <= 1'b1;
      else if (irq_clr) start_overrun <= 1'b0;
    end
  end

  assign start_pulse_int = start_acc;
  assign irq_pulse       = irq_tap;
  assign busy            = (state_q == BUSY);

endmodule

// File: rtl/glb_tile_evt_pipe.sv
// GLB tile staging: per-channel event gating/irq bookkeeping, clk_en delay, two packet pipes.
// Latency: clk_en 1 cycle; events per glb_evt_chan; packets PKT_LAT enabled cycles.
// Backpressure: none; packet stages hold while clk_en is low.
module glb_tile_evt_pipe
  import glb_tile_evt_pipe_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int START_LAT = START_LAT_DEF,
  parameter int IRQ_LAT   = IRQ_LAT_DEF,
  parameter int PKT_WIDTH = PKT_WIDTH_DEF,
  parameter int PKT_LAT   = PKT_LAT_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  output logic                 clk_en_d1,
  glb_tile_evt_pipe_if.slave   bus
);

  logic [PKT_WIDTH-1:0] pkt_in  [2];
  logic [PKT_WIDTH-1:0] pkt_out [2];

  // clk_en delayed one cycle for the core; deliberately not gated by itself
  always_ff @(posedge clk or negedge reset)
    if (!reset) clk_en_d1 <= 1'b0;
    else        clk_en_d1 <= clk_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    glb_evt_chan #(
      .START_LAT (START_LAT),
      .IRQ_LAT   (IRQ_LAT),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan (
      .clk             (clk),
      .reset           (reset),
      .start_pulse     (bus.start_pulse[i]),
      .done_pulse      (bus.done_pulse_int[i]),
      .irq_clr         (bus.irq_clr[i]),
      .start_pulse_int (bus.start_pulse_int[i]),
      .irq_pulse       (bus.irq_pulse[i]),
      .irq_pending     (bus.irq_pending[i]),
      .irq_count       (bus.irq_count[i*CNT_WIDTH +: CNT_WIDTH]),
      .busy            (bus.busy[i]),
      .start_overrun   (bus.start_overrun[i])
    );
  end

  // index 0 = west-to-east, 1 = east-to-west
  assign pkt_in[0]       = bus.pkt_w2e_in;
  assign pkt_in[1]       = bus.pkt_e2w_in;
  assign bus.pkt_w2e_out = pkt_out[0];
  assign bus.pkt_e2w_out = pkt_out[1];

  for (genvar d = 0; d < 2; d++) begin : g_pkt
    if (PKT_LAT == 0) begin : g_pass
      assign pkt_out[d] = reset ? pkt_in[d] : '0;
    end else begin : g_pipe
      logic [PKT_WIDTH-1:0] stg [PKT_LAT];
      // packet stages advance together only on enabled cycles
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < PKT_LAT; k++) stg[k] <= '0;
        end else if (clk_en) begin
          stg[0] <= pkt_in[d];
          for (int k = 1; k < PKT_LAT; k++) stg[k] <= stg[k-1];
        end
      end
      assign pkt_out[d] = stg[PKT_LAT-1];
    end
  end

endmodule

// File: tb/tb_glb_tile_evt_pipe.sv
// Directed bench for glb_tile_evt_pipe with a cycle-keyed scoreboard.
// Stimulus pushes expected values tagged with the cycle they must appear.
// A negedge monitor compares them and flags any unexpected start/irq pulse.
module tb_glb_tile_evt_pipe;

  localparam int NCH = 3;
  localparam int PW  = 64;
  localparam int CW  = 4;
  localparam int LAST_CYC = 115;

  localparam int S_SPI  = 0;
  localparam int S_IRQ  = 1;
  localparam int S_PEND = 2;
  localparam int S_CNT  = 3;
  localparam int S_BUSY = 4;
  localparam int S_OVR  = 5;
  localparam int S_CKE  = 6;
  localparam int S_W2E  = 7;
  localparam int S_E2W  = 8;
  localparam int NSIG   = 9;

  typedef struct {
    int          cyc;
    int          sig;
    logic [63:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_en = 1'b0;
  logic clk_en_d1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  glb_tile_evt_pipe_if #(.NUM_CH(NCH), .PKT_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  glb_tile_evt_pipe #(
    .NUM_CH(NCH), .START_LAT(1), .IRQ_LAT(1),
    .PKT_WIDTH(PW), .PKT_LAT(2), .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .clk_en_d1 (clk_en_d1),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(int s);
    case (s)
      S_SPI:   return "start_pulse_int";
      S_IRQ:   return "irq_pulse";
      S_PEND:  return "irq_pending";
      S_CNT:   return "irq_count";
      S_BUSY:  return "busy";
      S_OVR:   return "start_overrun";
      S_CKE:   return "clk_en_d1";
      S_W2E:   return "pkt_w2e_out";
      S_E2W:   return "pkt_e2w_out";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [63:0] sample(int s);
    case (s)
      S_SPI:   return 64'(bus.start_pulse_int);
      S_IRQ:   return 64'(bus.irq_pulse);
      S_PEND:  return 64'(bus.irq_pending);
      S_CNT:   return 64'(bus.irq_count);
      S_BUSY:  return 64'(bus.busy);
      S_OVR:   return 64'(bus.start_overrun);
      S_CKE:   return 64'(clk_en_d1);
      S_W2E:   return bus.pkt_w2e_out;
      S_E2W:   return bus.pkt_e2w_out;
      default: return 64'd0;
    endcase
  endfunction

  task automatic ex(int c, int s, logic [63:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic goto(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: compare everything due this cycle; pulses with no expectation are errors
  always @(negedge clk) begin
    bit          found;
    logic [63:0] got;
    for (int s = 0; s < NSIG; s++) begin
      found = 1'b0;
      got   = sample(s);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc && sbq[i].sig == s) begin
          n_tests++;
          if (got !== sbq[i].val) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h required=%h", sig_name(s), cyc, got, sbq[i].val);
          end
          sbq.delete(i);
          found = 1'b1;
        end
      end
      if (!found && (s == S_SPI || s == S_IRQ) && got != 64'd0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_%s cyc=%0d got=%h required=0", sig_name(s), cyc, got);
      end
    end
  end

  initial begin
    bus.start_pulse    = '0;
    bus.done_pulse_int = '0;
    bus.irq_clr        = '0;
    bus.pkt_w2e_in     = '0;
    bus.pkt_e2w_in     = '0;

    for (int t = 1; t <= LAST_CYC; t++) begin
      goto(t);
      // drive this cycle's inputs
      reset  = !(t < 3 || t == 106 || t == 107);
      clk_en = !(t >= 92 && t <= 94);
      bus.start_pulse    = {1'b0, 1'b0, (t == 10 || t == 20 || t == 100)};
      bus.done_pulse_int = {(t == 67 || t == 70),
                            ((t >= 30 && t <= 32) || (t >= 40 && t <= 59) || t == 105),
                            (t == 27)};
      bus.irq_clr        = {(t == 71), (t == 65), (t == 25 || t == 29)};
      bus.pkt_w2e_in     = (t == 80) ? 64'hA5 : (t == 105) ? 64'h5A : (t < 3) ? 64'hFF : 64'h0;
      bus.pkt_e2w_in     = (t == 90) ? 64'h11 : (t == 91) ? 64'h22 :
                           (t >= 92 && t <= 95) ? 64'h33 : 64'h0;

      // expected responses for what was just issued
      if (t == 2) for (int s = 0; s < NSIG; s++) ex(2, s, 64'd0);
      if (t == 4) ex(4, S_CKE, 64'd1);
      if (t == 10) begin
        ex(11, S_SPI, 64'h1); ex(11, S_BUSY, 64'h0); ex(12, S_BUSY, 64'h1);
      end
      if (t == 20) begin
        ex(21, S_SPI, 64'h0); ex(21, S_OVR, 64'h0); ex(22, S_OVR, 64'h1); ex(24, S_OVR, 64'h1);
      end
      if (t == 25) begin
        ex(26, S_OVR, 64'h0); ex(26, S_BUSY, 64'h1);
      end
      if (t == 27) begin
        ex(28, S_BUSY, 64'h0); ex(28, S_IRQ, 64'h1); ex(29, S_PEND, 64'h1); ex(29, S_CNT, 64'h001);
      end
      if (t == 29) begin
        ex(30, S_PEND, 64'h0); ex(30, S_CNT, 64'h000);
      end
      if ((t >= 30 && t <= 32) || (t >= 40 && t <= 59)) ex(t + 1, S_IRQ, 64'h2);
      if (t == 30) ex(32, S_CNT, 64'h010);
      if (t == 32) begin
        ex(34, S_PEND, 64'h2); ex(34, S_CNT, 64'h030);
      end
      if (t == 40) begin
        ex(52, S_CNT, 64'h0E0); ex(54, S_CNT, 64'h0F0); ex(61, S_CNT, 64'h0F0); ex(61, S_PEND, 64'h2);
      end
      if (t == 65) begin
        ex(66, S_CNT, 64'h000); ex(66, S_PEND, 64'h0);
      end
      if (t == 67) begin
        ex(68, S_IRQ, 64'h4); ex(69, S_CNT, 64'h100);
      end
      if (t == 70) begin
        ex(71, S_IRQ, 64'h4); ex(72, S_PEND, 64'h4); ex(72, S_CNT, 64'h100);
      end
      if (t == 80) begin
        ex(81, S_W2E, 64'h0); ex(82, S_W2E, 64'hA5); ex(83, S_W2E, 64'h0);
      end
      if (t == 90) begin
        ex(91, S_E2W, 64'h0);
        for (int k = 92; k <= 95; k++) ex(k, S_E2W, 64'h11);
        ex(96, S_E2W, 64'h22); ex(97, S_E2W, 64'h33); ex(98, S_E2W, 64'h0);
        ex(92, S_CKE, 64'h1); ex(93, S_CKE, 64'h0); ex(96, S_CKE, 64'h1);
      end
      if (t == 100) begin
        ex(101, S_SPI, 64'h1); ex(102, S_BUSY, 64'h1); ex(104, S_BUSY, 64'h1);
      end
      if (t == 105) begin
        ex(106, S_BUSY, 64'h0); ex(106, S_IRQ, 64'h0); ex(106, S_CKE, 64'h0);
        ex(106, S_PEND, 64'h0); ex(107, S_PEND, 64'h0); ex(107, S_CNT, 64'h0);
        ex(107, S_W2E, 64'h0);
        ex(108, S_IRQ, 64'h0); ex(109, S_IRQ, 64'h0); ex(109, S_BUSY, 64'h0);
        ex(109, S_PEND, 64'h0); ex(109, S_W2E, 64'h0);
      end
    end

    goto(LAST_CYC + 1);
    // anything still queued was never reached by the monitor
    while (sbq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unchecked_%s cyc=%0d got=none required=%h",
               sig_name(sbq[0].sig), sbq[0].cyc, sbq[0].val);
      void'(sbq.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glb_tile_evt_pipe.md
Name: glb_tile_evt_pipe

Overview:
Parametrised event and packet staging block for a GLB tile.
- Sits between the tile boundary and glb_core.
- Delays start pulses, interrupt pulses, clk_en and stream packets by configurable latencies.
- Adds a per-channel busy state machine that drops overlapping starts and flags them as overruns.
- Adds sticky interrupt pending bits with saturating event counters and a clear handshake, so back-to-back DMA completions are never lost.

Parameters:
NUM_CH, 3, number of event channels (e.g. strm_f2g, strm_g2f, pcfg_g2f).
START_LAT, 1, start-pulse delay in cycles (0 = passthrough).
IRQ_LAT, 1, done-to-interrupt delay in cycles (0 = passthrough).
PKT_WIDTH, 64, stream packet width in bits.
PKT_LAT, 1, packet pipeline stages per direction (0 = passthrough).
CNT_WIDTH, 4, per-channel interrupt counter width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
clk_en  in  1  tile clock enable
clk_en_d1  out  1  clk_en delayed 1 cycle, fed to core
start_pulse  in  NUM_CH  external start triggers
start_pulse_int  out  NUM_CH  accepted, delayed starts to core
done_pulse_int  in  NUM_CH  completion pulses from core
irq_pulse  out  NUM_CH  delayed interrupt pulses
irq_pending  out  NUM_CH  sticky pending bits
irq_count  out  NUM_CH*CNT_WIDTH  saturating event counts; channel i occupies [i*CNT_WIDTH +: CNT_WIDTH]
irq_clr  in  NUM_CH  one-cycle clear request per channel
busy  out  NUM_CH  channel state == BUSY
start_overrun  out  NUM_CH  sticky: a start was dropped while BUSY
pkt_w2e_in  in  PKT_WIDTH  west-to-east packet in
pkt_w2e_out  out  PKT_WIDTH  west-to-east packet out
pkt_e2w_in  in  PKT_WIDTH  east-to-west packet in
pkt_e2w_out  out  PKT_WIDTH  east-to-west packet out

Behaviour:
Reset:
- While reset==0, all registers and all outputs are 0, including every delay-line stage.
- In-flight pulses and packets are discarded; nothing replays after reset deasserts.

clk_en path:
- clk_en_d1 equals clk_en registered once. It is not gated.

Start path (per channel i):
- start_pulse[i] at cycle t reaches the delay-line tap at t+START_LAT (tap = start_pulse[i] itself when START_LAT=0).
- FSM states: IDLE, BUSY.
  - IDLE and tap=1: start_pulse_int[i]=1 in the same cycle; BUSY from the next cycle.
  - BUSY and tap=1 and done_pulse_int[i]=0: start is dropped, start_pulse_int stays 0, start_overrun[i] sets next cycle.
  - BUSY and done_pulse_int[i]=1 and tap=0: IDLE next cycle.
  - BUSY and tap=1 and done_pulse_int[i]=1 in the same cycle: start is accepted (start_pulse_int=1) and the channel stays BUSY.
  - done_pulse_int[i] while IDLE: FSM unchanged; the done is still forwarded to the interrupt path.
- start_overrun[i] is cleared only by reset or by irq_clr[i].
- Delay lines shift every cycle regardless of clk_en.

Interrupt path (per channel i):
- done_pulse_int[i] at cycle d produces irq_pulse[i]=1 at d+IRQ_LAT.
- At the cycle after irq_pulse[i]: irq_pending[i]=1, and irq_count increments, saturating at 2^CNT_WIDTH-1 with no wrap.
- irq_clr[i] at cycle c: irq_pending, irq_count and start_overrun are 0 at c+1.
- irq_clr[i] and irq_pulse[i] in the same cycle: the set wins, giving pending=1 and count=1 at c+1.
- Consecutive done pulses are each forwarded; none are merged on the irq_pulse output.

Packet path:
- Each direction is a PKT_LAT-stage register chain.
- All stages advance only when clk_en=1 and hold otherwise.
- Output is the last stage; it equals the input combinationally when PKT_LAT=0.

Decomposition:
- The team package holds localparam defaults and the typedef evt_state_e {IDLE, BUSY}.
- Sub-module glb_evt_chan implements one channel: start delay line, FSM, IRQ delay line, pending bit, counter and overrun bit.
- The top instantiates glb_evt_chan NUM_CH times in a generate loop, plus two packet pipes and the clk_en flop.

Test Plan:
- Reset, then start_pulse[0] at cycle 10 -> start_pulse_int[0]=1 at cycle 11; busy[0]=1 from cycle 12.
- Busy channel 0, start_pulse[0] again at cycle 20 -> no start_pulse_int at 21; start_overrun[0]=1 at 22. Then irq_clr[0] -> overrun 0.
- done_pulse_int[1] at cycles 30, 31, 32 -> irq_pulse[1] at 31, 32, 33; irq_count[1]=3 and irq_pending[1]=1 at 34. Drive 20 pulses with CNT_WIDTH=4 -> count holds at 15.
- irq_clr[2] coincident with irq_pulse[2] -> pending[2]=1 and count[2]=1 next cycle.
- PKT_LAT=2: drive pkt_w2e_in=0xA5 with clk_en=1 -> output after 2 cycles; lower clk_en for 3 cycles mid-flight -> output holds, then resumes with no loss or duplication.
- Assert reset (0) while channel 0 is BUSY and a done pulse is in the IRQ delay line -> all outputs 0, and no irq_pulse after release.
